// File: rtl/fp_pkg.sv
// fp_pkg: shared opcodes, field widths, binary32 layout and helpers for fp_alu.
// The rounding mode is selected with the FP_ROUND_NEAREST_EN macro in fp_round_pack.
package fp_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int BIAS   = 127;

    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        FP_OP_ADD  = 2'h0,
        FP_OP_SUB  = 2'h1,
        FP_OP_MUL  = 2'h2,
        FP_OP_PASS = 2'h3
    } fp_op_e;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp_t;

    // Leading-zero count of a 27-bit significand; returns 27 for all-zero input.
    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd27;
        found = 1'b0;
        for (int unsigned i = 0; i < 27; i++) begin
            if (!found && v[26-i]) begin
                n     = 5'(i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/fp_round_pack.sv
// fp_round_pack: rounds a normalised significand {1.m[23:0], g, r, s}, applies
// overflow/underflow handling and packs a binary32 word.
// FP_ROUND_NEAREST_EN defined: round-to-nearest-even; undefined: truncate.
module fp_round_pack
    import fp_pkg::*;
(
    input  logic               sign,
    input  logic signed [10:0] exp_unb,
    input  logic [26:0]        sig,
    output logic [31:0]        result
);

    logic [24:0]        mant_r;
    logic signed [11:0] exp_b;
    logic [22:0]        frac;

`ifndef FP_ROUND_NEAREST_EN
    logic unused_grs;
    assign unused_grs = ^sig[2:0];
`endif

    // Round, re-bias (a rounding carry bumps the exponent) and saturate/flush.
    always_comb begin
        mant_r = {1'b0, sig[26:3]};
`ifdef FP_ROUND_NEAREST_EN
        if (sig[2] && (sig[1] || sig[0] || sig[3])) begin
            mant_r = mant_r + 25'd1;
        end
`endif
        exp_b  = {exp_unb[10], exp_unb} + 12'(BIAS) + {11'd0, mant_r[24]};
        frac   = mant_r[24] ? mant_r[23:1] : mant_r[22:0];
        result = {sign, exp_b[7:0], frac};
        if (exp_b >= 12'sd255) begin
            result = {sign, 8'hFF, 23'd0};
        end else if (exp_b <= 12'sd0) begin
            result = {sign, 31'd0};
        end
    end

endmodule

// File: rtl/fp_alu.sv
// fp_alu: binary32 add / subtract / multiply / pass with one output register.
// Subnormal inputs read as zero; outputs are flushed to zero on underflow.
// Rounding mode: FP_ROUND_NEAREST_EN (see fp_round_pack).
module fp_alu
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] in0,
    input  logic [31:0] in1,
    input  logic [1:0]  operand,
    output logic [31:0] O
);

    fp_op_e op;
    fp_t    a, b;
    logic   a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [23:0] a_man, b_man;
    logic [7:0]  a_exp, b_exp;

    assign op = fp_op_e'(operand);
    assign a  = fp_t'(in0);
    assign b  = fp_t'(in1);

    assign a_zero = (a.exp == '0);
    assign b_zero = (b.exp == '0);
    assign a_inf  = (a.exp == '1) && (a.frac == '0);
    assign b_inf  = (b.exp == '1) && (b.frac == '0);
    assign a_nan  = (a.exp == '1) && (a.frac != '0);
    assign b_nan  = (b.exp == '1) && (b.frac != '0);
    assign a_man  = a_zero ? '0 : {1'b1, a.frac};
    assign b_man  = b_zero ? '0 : {1'b1, b.frac};
    assign a_exp  = a.exp;
    assign b_exp  = b.exp;

    // add/sub path signals
    logic               b_sign_eff, swap, big_sign, sml_sign, eff_sub;
    logic [7:0]         big_exp, sml_exp, shamt;
    logic [5:0]         shamt_c;
    logic [23:0]        big_man, sml_man;
    logic [49:0]        wide;
    logic [26:0]        sml_ext, big_ext, add_sig;
    logic [27:0]        sum;
    logic [4:0]         lz;
    logic signed [10:0] add_exp;
    logic               add_zero, add_zero_sign;

    // Align the smaller magnitude (clamped shift keeps everything as sticky), add, normalise.
    always_comb begin
        b_sign_eff = b.sign ^ (op == FP_OP_SUB);
        swap       = {b_exp, b_man} > {a_exp, a_man};
        big_sign   = swap ? b_sign_eff : a.sign;
        sml_sign   = swap ? a.sign : b_sign_eff;
        big_exp    = swap ? b_exp : a_exp;
        sml_exp    = swap ? a_exp : b_exp;
        big_man    = swap ? b_man : a_man;
        sml_man    = swap ? a_man : b_man;
        shamt      = big_exp - sml_exp;
        shamt_c    = (shamt >= 8'd26) ? 6'd26 : shamt[5:0];
        wide       = {sml_man, 26'd0} >> shamt_c;
        sml_ext    = {wide[49:24], |wide[23:0]};
        big_ext    = {big_man, 3'b000};
        eff_sub    = big_sign ^ sml_sign;
        sum        = eff_sub ? ({1'b0, big_ext} - {1'b0, sml_ext})
                             : ({1'b0, big_ext} + {1'b0, sml_ext});
        lz         = lzc27(sum[26:0]);
        if (sum[27]) begin
            add_sig = {sum[27:2], sum[1] | sum[0]};
            add_exp = {3'b000, big_exp} - 11'sd127 + 11'sd1;
        end else begin
            add_sig = sum[26:0] << lz;
            add_exp = {3'b000, big_exp} - 11'sd127 - {6'd0, lz};
        end
        add_zero      = (sum == '0);
        add_zero_sign = eff_sub ? 1'b0 : big_sign;
    end

    // multiply path signals
    logic [47:0]        prod;
    logic [10:0]        mul_exp_base;
    logic [26:0]        mul_sig;
    logic signed [10:0] mul_exp;
    logic               mul_sign;

    // 24x24 product, normalised by at most one position.
    always_comb begin
        prod         = 48'(a_man) * 48'(b_man);
        mul_sign     = a.sign ^ b.sign;
        mul_exp_base = {3'b000, a_exp} + {3'b000, b_exp} - 11'd254;
        if (prod[47]) begin
            mul_sig = {prod[47:22], |prod[21:0]};
            mul_exp = mul_exp_base + 11'd1;
        end else begin
            mul_sig = {prod[46:21], |prod[20:0]};
            mul_exp = mul_exp_base;
        end
    end

    logic               rp_sign;
    logic signed [10:0] rp_exp;
    logic [26:0]        rp_sig;
    logic [31:0]        rp_result;
    logic [31:0]        result;

    // One rounder serves both arithmetic paths.
    always_comb begin
        rp_sign = big_sign;
        rp_exp  = add_exp;
        rp_sig  = add_sig;
        if (op == FP_OP_MUL) begin
            rp_sign = mul_sign;
            rp_exp  = mul_exp;
            rp_sig  = mul_sig;
        end
    end

    fp_round_pack u_round_pack (
        .sign    (rp_sign),
        .exp_unb (rp_exp),
        .sig     (rp_sig),
        .result  (rp_result)
    );

    // Special-case priority ahead of the arithmetic result.
    always_comb begin
        result = rp_result;
        case (op)
            FP_OP_PASS: result = in0;
            FP_OP_MUL: begin
                if (a_nan || b_nan)                            result = FP_QNAN;
                else if ((a_inf && b_zero) || (a_zero && b_inf)) result = FP_QNAN;
                else if (a_inf || b_inf)                       result = {mul_sign, 8'hFF, 23'd0};
                else if (a_zero || b_zero)                     result = {mul_sign, 31'd0};
                else                                           result = rp_result;
            end
            default: begin
                if (a_nan || b_nan)                                 result = FP_QNAN;
                else if (a_inf && b_inf && (a.sign ^ b_sign_eff))   result = FP_QNAN;
                else if (a_inf)                                     result = {a.sign, 8'hFF, 23'd0};
                else if (b_inf)                                     result = {b_sign_eff, 8'hFF, 23'd0};
                else if (add_zero)                                  result = {add_zero_sign, 31'd0};
                else                                                result = rp_result;
            end
        endcase
    end

    // Output register; reset clears it asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            O <= '0;
        end else begin
            O <= result;
        end
    end

endmodule

// File: tb/tb_fp_alu.sv
// tb_fp_alu: directed-vector bench for fp_alu; expectations follow the
// build's FP_ROUND_NEAREST_EN setting.
module tb_fp_alu;

    localparam logic [1:0] OP_ADD  = 2'h0;
    localparam logic [1:0] OP_SUB  = 2'h1;
    localparam logic [1:0] OP_MUL  = 2'h2;
    localparam logic [1:0] OP_PASS = 2'h3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] in0 = '0;
    logic [31:0] in1 = '0;
    logic [1:0]  operand = OP_ADD;
    logic [31:0] O;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fp_alu dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in0     (in0),
        .in1     (in1),
        .operand (operand),
        .O       (O)
    );

    task automatic test_reset();
        in0 = 32'h3F80_0000; in1 = 32'h4000_0000; operand = OP_ADD;
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (O !== 32'h0) begin
            n_bad++; $display("FAIL reset_async: O=%h expected %h", O, 32'h0);
        end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (O !== 32'h0) begin
            n_bad++; $display("FAIL reset_hold: O=%h expected %h", O, 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        logic [31:0] va [7] = '{32'h3F80_0000, 32'h3FC0_0000, 32'hC040_0000, 32'h3F80_0000,
                                32'h8000_0000, 32'h0000_0000, 32'h0000_0001};
        logic [31:0] vb [7] = '{32'h4000_0000, 32'h3E80_0000, 32'h3F80_0000, 32'h3080_0000,
                                32'h8000_0000, 32'h8000_0000, 32'h3F80_0000};
        logic [31:0] ve [7] = '{32'h4040_0000, 32'h3FE0_0000, 32'hC000_0000, 32'h3F80_0000,
                                32'h8000_0000, 32'h0000_0000, 32'h3F80_0000};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            in0 = va[i]; in1 = vb[i]; operand = OP_ADD;
            @(posedge clk);
            #1;
            n_cmp++;
            if (O !== ve[i]) begin
                n_bad++; $display("FAIL add[%0d]: O=%h expected %h", i, O, ve[i]);
            end
        end
    endtask

    task automatic test_sub();
        logic [31:0] va [4] = '{32'h4300_0000, 32'h3F80_0000, 32'h4000_0000, 32'h3F80_0000};
        logic [31:0] vb [4] = '{32'h4300_0000, 32'h4000_0000, 32'h3F80_0000, 32'h3FC0_0000};
        logic [31:0] ve [4] = '{32'h0000_0000, 32'hBF80_0000, 32'h3F80_0000, 32'hBF00_0000};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in0 = va[i]; in1 = vb[i]; operand = OP_SUB;
            @(posedge clk);
            #1;
            n_cmp++;
            if (O !== ve[i]) begin
                n_bad++; $display("FAIL sub[%0d]: O=%h expected %h", i, O, ve[i]);
            end
        end
    endtask

    task automatic test_mul();
        logic [31:0] va [4] = '{32'h4000_0000, 32'h4300_0000, 32'h3FC0_0000, 32'hC040_0000};
        logic [31:0] vb [4] = '{32'h3F00_0000, 32'h3F00_0000, 32'h3FC0_0000, 32'h4000_0000};
        logic [31:0] ve [4] = '{32'h3F80_0000, 32'h4280_0000, 32'h4010_0000, 32'hC0C0_0000};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in0 = va[i]; in1 = vb[i]; operand = OP_MUL;
            @(posedge clk);
            #1;
            n_cmp++;
            if (O !== ve[i]) begin
                n_bad++; $display("FAIL mul[%0d]: O=%h expected %h", i, O, ve[i]);
            end
        end
    endtask

    task automatic test_round();
        logic [31:0] va [4] = '{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3FFF_FFFF};
        logic [31:0] vb [4] = '{32'h3440_0000, 32'h3380_0000, 32'h33C0_0000, 32'h33C0_0000};
`ifdef FP_ROUND_NEAREST_EN
        logic [31:0] ve [4] = '{32'h3F80_0002, 32'h3F80_0000, 32'h3F80_0001, 32'h4000_0000};
`else
        logic [31:0] ve [4] = '{32'h3F80_0001, 32'h3F80_0000, 32'h3F80_0000, 32'h3FFF_FFFF};
`endif
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in0 = va[i]; in1 = vb[i]; operand = OP_ADD;
            @(posedge clk);
            #1;
            n_cmp++;
            if (O !== ve[i]) begin
                n_bad++; $display("FAIL round[%0d]: O=%h expected %h", i, O, ve[i]);
            end
        end
    endtask

    task automatic test_specials();
        logic [31:0] va [10] = '{32'h7F7F_FFFF, 32'h7F80_0000, 32'h0000_0000, 32'h0080_0000,
                                 32'h7F80_0001, 32'h7F80_0000, 32'h3F80_0000, 32'hFF80_0000,
                                 32'h7F7F_FFFF, 32'h8080_0000};
        logic [31:0] vb [10] = '{32'h4000_0000, 32'h7F80_0000, 32'hFF80_0000, 32'h3F00_0000,
                                 32'h3F80_0000, 32'h3F80_0000, 32'h7F80_0000, 32'h4000_0000,
                                 32'h7F7F_FFFF, 32'h3F00_0000};
        logic [1:0]  vo [10] = '{OP_MUL, OP_SUB, OP_MUL, OP_MUL, OP_ADD,
                                 OP_ADD, OP_SUB, OP_MUL, OP_ADD, OP_MUL};
        logic [31:0] ve [10] = '{32'h7F80_0000, 32'h7FC0_0000, 32'h7FC0_0000, 32'h0000_0000,
                                 32'h7FC0_0000, 32'h7F80_0000, 32'hFF80_0000, 32'hFF80_0000,
                                 32'h7F80_0000, 32'h8000_0000};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in0 = va[i]; in1 = vb[i]; operand = vo[i];
            @(posedge clk);
            #1;
            n_cmp++;
            if (O !== ve[i]) begin
                n_bad++; $display("FAIL special[%0d]: O=%h expected %h", i, O, ve[i]);
            end
        end
    endtask

    task automatic test_pass();
        logic [31:0] va [2] = '{32'h7FC1_2345, 32'hFF80_0001};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in0 = va[i]; in1 = 32'h4000_0000; operand = OP_PASS;
            @(posedge clk);
            #1;
            n_cmp++;
            if (O !== va[i]) begin
                n_bad++; $display("FAIL pass[%0d]: O=%h expected %h", i, O, va[i]);
            end
        end
    endtask

    // Opcode and data change together every cycle; each edge result checked.
    task automatic test_back_to_back();
        logic [31:0] va [5] = '{32'h3F80_0000, 32'h4000_0000, 32'h1234_5678, 32'h4300_0000, 32'h3F80_0000};
        logic [31:0] vb [5] = '{32'h4000_0000, 32'h3F00_0000, 32'h3F80_0000, 32'h4300_0000, 32'h4000_0000};
        logic [1:0]  vo [5] = '{OP_ADD, OP_MUL, OP_PASS, OP_SUB, OP_SUB};
        logic [31:0] ve [5] = '{32'h4040_0000, 32'h3F80_0000, 32'h1234_5678, 32'h0000_0000, 32'hBF80_0000};
        @(negedge clk);
        in0 = va[0]; in1 = vb[0]; operand = vo[0];
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (O !== ve[i]) begin
                n_bad++; $display("FAIL b2b[%0d]: O=%h expected %h", i, O, ve[i]);
            end
            if (i < 4) begin
                in0 = va[i+1]; in1 = vb[i+1]; operand = vo[i+1];
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        in0 = 32'h4000_0000; in1 = 32'h3F00_0000; operand = OP_MUL;
        @(posedge clk);
        #1;
        n_cmp++;
        if (O !== 32'h3F80_0000) begin
            n_bad++; $display("FAIL mid_pre: O=%h expected %h", O, 32'h3F80_0000);
        end
        in0 = 32'h3F80_0000; in1 = 32'h4000_0000; operand = OP_ADD;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (O !== 32'h0) begin
            n_bad++; $display("FAIL mid_async: O=%h expected %h", O, 32'h0);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (O !== 32'h0) begin
            n_bad++; $display("FAIL mid_discard: O=%h expected %h", O, 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        in0 = 32'h7FC1_2345; in1 = 32'h0; operand = OP_PASS;
        @(posedge clk);
        #1;
        n_cmp++;
        if (O !== 32'h7FC1_2345) begin
            n_bad++; $display("FAIL mid_release: O=%h expected %h", O, 32'h7FC1_2345);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_round();
        test_specials();
        test_pass();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
